// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: four-way round-robin arbiter that drives the select and
// enable pins of a 2-to-4 decoder. One owner at a time, with a one-cycle dead
// gap (en=0) between consecutive owners. All outputs are registered.
// Optional build macro ARB_TIMEOUT_EN adds a hold counter that forces release
// after MAX_HOLD grant cycles and pulses timeout during the resulting gap.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int RST_PTR  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] sel_nxt;
  logic       en_nxt;
  logic       busy_nxt;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       force_rel;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("decoder_rr_arbiter: MAX_HOLD must be within 1..255");
  end
  if (RST_PTR < 0 || RST_PTR > 3) begin : g_bad_rst_ptr
    $error("decoder_rr_arbiter: RST_PTR must be within 0..3");
  end

  // Scan from the pointer upward (mod 4); walking offsets downward lets the
  // smallest offset overwrite the result last, so it wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {win_vld, win_idx} = rr_pick(req, ptr);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign force_rel = (state == GRANT) && req[owner] && (hold_cnt == 8'(MAX_HOLD - 1));

  // Hold counter sits at zero outside GRANT so every grant starts from zero;
  // timeout flags the gap cycle that follows a forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state_nxt == GRANT && state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
      timeout  <= force_rel;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and next-output decode; outputs are loaded into registers below.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    sel_nxt   = sel;
    en_nxt    = en;
    busy_nxt  = busy;
    unique case (state)
      IDLE, GAP: begin
        if (win_vld) begin
          state_nxt = GRANT;
          owner_nxt = win_idx;
          grant_nxt = 4'b0001 << win_idx;
          sel_nxt   = win_idx;
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
          sel_nxt   = 2'b00;
          en_nxt    = 1'b0;
          busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        if (!req[owner] || force_rel) begin
          state_nxt = GAP;
          grant_nxt = 4'b0000;
          sel_nxt   = owner;
          en_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          ptr_nxt   = owner + 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        sel_nxt   = 2'b00;
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs; reset acts without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'(RST_PTR);
      grant <= 4'b0000;
      sel   <= 2'b00;
      en    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
      sel   <= sel_nxt;
      en    <= en_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule
